// File: rtl/bcd_timer_pkg.sv
// Shared types and constants for the BCD event timer.
// States, digit width and the largest decimal digit value.
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

endpackage

// File: rtl/bcd_timer_ctrl_digit.sv
// One decade (0-9) counter digit; carry is high when an increment rolls 9 -> 0.
module bcd_digit
    import bcd_timer_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   inc,
    output logic [BCD_DIGIT_W-1:0] q,
    output logic                   carry
);

    assign carry = inc && (q == BCD_MAX_DIGIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= (q == BCD_MAX_DIGIT) ? '0 : q + 1'b1;
        end
    end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// N-digit BCD event timer: command FSM, live terminal compare and digit cascade.
// Optional tick prescaler is enabled by defining BCD_TIMER_PRESCALE_EN.
//
// state | meaning
// IDLE  | stopped, count held, waiting for start
// RUN   | counting qualified ticks
// PAUSE | stopped mid-run, count held, start resumes
// DONE  | one-shot terminal reached, count held at term_bcd
module bcd_timer_ctrl
    import bcd_timer_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int PRESCALE_DIV = 10
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            stop,
    input  logic                            clear,
    input  logic                            tick,
    input  logic                            reload,
    input  logic [BCD_DIGIT_W*N_DIGITS-1:0] term_bcd,
    output logic [BCD_DIGIT_W*N_DIGITS-1:0] count_bcd,
    output logic                            busy,
    output logic                            done
);

    state_t r_state;
    logic   r_busy;
    logic   r_done;

    logic                w_start_fresh;
    logic                w_run_tick;
    logic                w_qtick;
    logic                w_match;
    logic                w_terminal;
    logic                w_digit_clr;
    logic [N_DIGITS-1:0] w_inc;
    logic                w_carry_unused;

    if (PRESCALE_DIV < 1) begin : g_bad_div
        $error("PRESCALE_DIV must be >= 1");
    end

    // stop only has an effect in RUN, so it does not mask start elsewhere
    assign w_start_fresh = start && !clear && ((r_state == IDLE) || (r_state == DONE));
    assign w_run_tick    = tick && !clear && !stop && (r_state == RUN);

`ifdef BCD_TIMER_PRESCALE_EN
    localparam int PRE_W = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(PRESCALE_DIV - 1);

    logic [PRE_W-1:0] r_pre;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre <= PRE_LOAD;
        end else if (clear || w_start_fresh) begin
            r_pre <= PRE_LOAD;
        end else if (w_run_tick) begin
            r_pre <= (r_pre == '0) ? PRE_LOAD : r_pre - 1'b1;
        end
    end

    assign w_qtick = w_run_tick && (r_pre == '0);
`else
    assign w_qtick = w_run_tick;
`endif

    // digits never exceed 9, so a term with any digit > 9 can never match
    assign w_match     = (count_bcd == term_bcd);
    assign w_terminal  = w_qtick && w_match;
    assign w_digit_clr = clear || w_start_fresh || (w_terminal && reload);
    assign w_inc[0]    = w_qtick && !w_match;

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        if (k < N_DIGITS - 1) begin : g_mid
            bcd_digit u_digit (
                .clk   (clk),
                .reset (reset),
                .clr   (w_digit_clr),
                .inc   (w_inc[k]),
                .q     (count_bcd[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .carry (w_inc[k+1])
            );
        end else begin : g_last
            bcd_digit u_digit (
                .clk   (clk),
                .reset (reset),
                .clr   (w_digit_clr),
                .inc   (w_inc[k]),
                .q     (count_bcd[k*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .carry (w_carry_unused)
            );
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_terminal;
            if (clear) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (stop) begin
                            r_state <= PAUSE;
                        end else if (w_terminal && !reload) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        if (start) begin
                            r_state <= RUN;
                        end
                    end
                    DONE: begin
                        if (start) begin
                            r_state <= RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed self-checking bench for bcd_timer_ctrl (default build, no prescaler).
module tb_bcd_timer_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, stop, clear, tick, reload;
    logic [15:0] term_bcd;
    logic [15:0] count_bcd;
    logic        busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    bcd_timer_ctrl #(.N_DIGITS(4), .PRESCALE_DIV(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .clear     (clear),
        .tick      (tick),
        .reload    (reload),
        .term_bcd  (term_bcd),
        .count_bcd (count_bcd),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] c, input logic b, input logic d);
        chk({tag, ".count"}, count_bcd, c);
        chk({tag, ".busy"}, {15'd0, busy}, {15'd0, b});
        chk({tag, ".done"}, {15'd0, done}, {15'd0, d});
    endtask

    // apply current inputs at one rising edge, sample 1ns later, drop strobes
    task automatic step();
        @(posedge clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        tick = 1'b0; reload = 1'b0; term_bcd = 16'h0000;
        step(); step();
        chk_out("reset", 16'h0000, 1'b0, 1'b0);
        reset = 1'b0;
        step();
        chk_out("post_reset", 16'h0000, 1'b0, 1'b0);

        // one-shot to 0x0012
        term_bcd = 16'h0012; reload = 1'b0;
        start = 1'b1; step();
        chk_out("os_start", 16'h0000, 1'b1, 1'b0);
        tick = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk_out("os_tick", to_bcd(i), 1'b1, 1'b0);
        end
        step();
        chk_out("os_term", 16'h0012, 1'b0, 1'b1);
        step();
        chk_out("os_hold1", 16'h0012, 1'b0, 1'b0);
        step();
        chk_out("os_hold2", 16'h0012, 1'b0, 1'b0);

        // auto-reload at 0x0003
        tick = 1'b0; term_bcd = 16'h0003; reload = 1'b1;
        start = 1'b1; step();
        chk_out("rl_start", 16'h0000, 1'b1, 1'b0);
        tick = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk_out("rl_tick", to_bcd(i % 4), 1'b1, (i % 4) == 0);
        end
        tick = 1'b0; clear = 1'b1; step();
        chk_out("rl_clear", 16'h0000, 1'b0, 1'b0);

        // stop/resume, start ignored in RUN, clear priority
        term_bcd = 16'h0099; reload = 1'b0;
        start = 1'b1; step();
        tick = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk_out("pr_at5", 16'h0005, 1'b1, 1'b0);
        stop = 1'b1; step();
        chk_out("pr_stop_tick", 16'h0005, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step();
        chk_out("pr_paused", 16'h0005, 1'b1, 1'b0);
        tick = 1'b0; start = 1'b1; step();
        chk_out("pr_resume", 16'h0005, 1'b1, 1'b0);
        tick = 1'b1; step();
        chk_out("pr_tick6", 16'h0006, 1'b1, 1'b0);
        start = 1'b1; step();
        chk_out("pr_start_in_run", 16'h0007, 1'b1, 1'b0);
        clear = 1'b1; start = 1'b1; step();
        chk_out("pr_clr_start_tick", 16'h0000, 1'b0, 1'b0);
        step();
        chk_out("pr_idle_tick", 16'h0000, 1'b0, 1'b0);

        // carry chain and all-9s wrap with an unreachable terminal
        tick = 1'b0; term_bcd = 16'h9999;
        start = 1'b1; step();
        tick = 1'b1;
        for (int i = 0; i < 999; i++) step();
        chk_out("cy_0999", 16'h0999, 1'b1, 1'b0);
        step();
        chk_out("cy_1000", 16'h1000, 1'b1, 1'b0);
        term_bcd = 16'h00A0;
        n_done = 0;
        for (int i = 0; i < 8999; i++) begin
            step();
            if (done) n_done++;
        end
        chk_out("wr_9999", 16'h9999, 1'b1, 1'b0);
        step();
        chk_out("wr_0000", 16'h0000, 1'b1, 1'b0);
        chk("wr_no_done", 16'(n_done), 16'd0);

        // term of zero: first tick is terminal
        tick = 1'b0; clear = 1'b1; step();
        term_bcd = 16'h0000; start = 1'b1; step();
        tick = 1'b1; step();
        chk_out("t0_first", 16'h0000, 1'b0, 1'b1);

        // async reset in the middle of a run
        tick = 1'b0; term_bcd = 16'h0099; start = 1'b1; step();
        tick = 1'b1;
        for (int i = 0; i < 37; i++) step();
        chk_out("ar_at37", 16'h0037, 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        chk_out("ar_async", 16'h0000, 1'b0, 1'b0);
        step(); step();
        reset = 1'b0;
        step(); step();
        chk_out("ar_released", 16'h0000, 1'b0, 1'b0);
        start = 1'b1; tick = 1'b0; step();
        tick = 1'b1; step();
        chk_out("ar_restart", 16'h0001, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
